// File: rtl/operand_fetch_stage_if.sv
// Operand-fetch stage bundle: decode-side request, write-back port, flush and execute-side response.
// Latency: none (signal bundle only); the stage registers the response one cycle after accept.
// Backpressure: in_ready is driven by the stage; out_ready is driven by execute.
//
// Port summary (slave = the stage, master = the surrounding pipeline/bench):
//   flush                              kill the in-flight output and this cycle's input
//   in_valid / in_ready                decode handshake
//   in_rs1_* / in_rs2_* / in_rd_*      register selects and enables
//   in_funct3 / in_funct7 / in_imm     {value, dv} fields
//   in_opcode                          opcode encoding
//   wb_en / wb_addr / wb_data          register-file write-back
//   out_valid / out_ready              execute handshake
//   out_rs1 / out_rs2                  {data, dv}
//   out_rd                             {addr, en}
//   out_funct3 / out_funct7 / out_imm / out_opcode   registered copies of the inputs
interface operand_fetch_stage_if #(
    parameter int DATA_W    = 32,
    parameter int REG_SEL_W = 5
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [REG_SEL_W-1:0] in_rs1_addr;
    logic                 in_rs1_en;
    logic [REG_SEL_W-1:0] in_rs2_addr;
    logic                 in_rs2_en;
    logic [REG_SEL_W-1:0] in_rd_addr;
    logic                 in_rd_en;
    logic [3:0]           in_funct3;
    logic [7:0]           in_funct7;
    logic [DATA_W:0]      in_imm;
    logic [6:0]           in_opcode;

    logic                 wb_en;
    logic [REG_SEL_W-1:0] wb_addr;
    logic [DATA_W-1:0]    wb_data;

    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W:0]      out_rs1;
    logic [DATA_W:0]      out_rs2;
    logic [REG_SEL_W:0]   out_rd;
    logic [3:0]           out_funct3;
    logic [7:0]           out_funct7;
    logic [DATA_W:0]      out_imm;
    logic [6:0]           out_opcode;

    // Upstream/downstream environment view.
    modport master (
        output flush, in_valid, in_rs1_addr, in_rs1_en, in_rs2_addr, in_rs2_en,
               in_rd_addr, in_rd_en, in_funct3, in_funct7, in_imm, in_opcode,
               wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_rs1, out_rs2, out_rd,
               out_funct3, out_funct7, out_imm, out_opcode
    );

    // Stage view.
    modport slave (
        input  flush, in_valid, in_rs1_addr, in_rs1_en, in_rs2_addr, in_rs2_en,
               in_rd_addr, in_rd_en, in_funct3, in_funct7, in_imm, in_opcode,
               wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_rs1, out_rs2, out_rd,
               out_funct3, out_funct7, out_imm, out_opcode
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute operand fetch: reads rs1/rs2 from an internal register file and registers the bundle.
// Latency 1 cycle from accept to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; a stalled output holds every field stable.
//
// Ports: clk (rising edge), rst (synchronous, active high), bus (operand_fetch_stage_if.slave).
// The DATA_W / REG_SEL_W parameters must match those of the connected interface.
// Optional feature macro OPFETCH_BYPASS_EN: forwards same-cycle write-back data into captured
// operands and refreshes held operands while the output is stalled. Without it, operands
// never change after capture and hazards are left to upstream logic.
module operand_fetch_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_SEL_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_fetch_stage_if.slave bus
);
    localparam int NREG = 1 << REG_SEL_W;

    // ------------------------------------------------------------------
    // Register file. Entry 0 is never written, so it stays at its reset
    // value; reads of address 0 are additionally forced to zero below.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_q [NREG];
    logic              wb_wr;

    assign wb_wr = bus.wb_en && (bus.wb_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_wr) begin
            // Write-back is independent of stall and flush.
            rf_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic out_valid_q, out_valid_d;
    logic accept;
    logic stall;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
    assign stall        = out_valid_q && !bus.out_ready;

    // ------------------------------------------------------------------
    // Operand read
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    always_comb begin
        rs1_data = '0;
        if (bus.in_rs1_en && (bus.in_rs1_addr != '0)) begin
            rs1_data = rf_q[bus.in_rs1_addr];
`ifdef OPFETCH_BYPASS_EN
            // The write landing at this edge is visible to the capture.
            if (wb_wr && (bus.wb_addr == bus.in_rs1_addr)) begin
                rs1_data = bus.wb_data;
            end
`endif
        end
    end

    always_comb begin
        rs2_data = '0;
        if (bus.in_rs2_en && (bus.in_rs2_addr != '0)) begin
            rs2_data = rf_q[bus.in_rs2_addr];
`ifdef OPFETCH_BYPASS_EN
            if (wb_wr && (bus.wb_addr == bus.in_rs2_addr)) begin
                rs2_data = bus.wb_data;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Output bundle registers
    // ------------------------------------------------------------------
    logic [DATA_W:0]    out_rs1_q,    out_rs1_d;
    logic [DATA_W:0]    out_rs2_q,    out_rs2_d;
    logic [REG_SEL_W:0] out_rd_q,     out_rd_d;
    logic [3:0]         out_funct3_q, out_funct3_d;
    logic [7:0]         out_funct7_q, out_funct7_d;
    logic [DATA_W:0]    out_imm_q,    out_imm_d;
    logic [6:0]         out_opcode_q, out_opcode_d;

`ifdef OPFETCH_BYPASS_EN
    // Source addresses of the held operands, needed to match later writes.
    logic [REG_SEL_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [REG_SEL_W-1:0] rs2_addr_q, rs2_addr_d;
`endif

    always_comb begin
        out_rs1_d    = out_rs1_q;
        out_rs2_d    = out_rs2_q;
        out_rd_d     = out_rd_q;
        out_funct3_d = out_funct3_q;
        out_funct7_d = out_funct7_q;
        out_imm_d    = out_imm_q;
        out_opcode_d = out_opcode_q;
`ifdef OPFETCH_BYPASS_EN
        rs1_addr_d   = rs1_addr_q;
        rs2_addr_d   = rs2_addr_q;
`endif

        if (accept) begin
            out_rs1_d    = {rs1_data, bus.in_rs1_en};
            out_rs2_d    = {rs2_data, bus.in_rs2_en};
            out_rd_d     = {bus.in_rd_addr, bus.in_rd_en};
            out_funct3_d = bus.in_funct3;
            out_funct7_d = bus.in_funct7;
            out_imm_d    = bus.in_imm;
            out_opcode_d = bus.in_opcode;
`ifdef OPFETCH_BYPASS_EN
            rs1_addr_d   = bus.in_rs1_addr;
            rs2_addr_d   = bus.in_rs2_addr;
`endif
        end
`ifdef OPFETCH_BYPASS_EN
        else if (stall && wb_wr) begin
            // A held operand tracks writes to its source register so that
            // execute sees the newest value once it accepts. dv=0 operands
            // were never read and stay zero.
            if (out_rs1_q[0] && (rs1_addr_q == bus.wb_addr)) begin
                out_rs1_d = {bus.wb_data, 1'b1};
            end
            if (out_rs2_q[0] && (rs2_addr_q == bus.wb_addr)) begin
                out_rs2_d = {bus.wb_data, 1'b1};
            end
        end
`endif
    end

    // Flush wins over everything but reset; a completed handshake with no
    // new accept empties the stage while payload fields keep their value.
    always_comb begin
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_rs1_q    <= '0;
            out_rs2_q    <= '0;
            out_rd_q     <= '0;
            out_funct3_q <= '0;
            out_funct7_q <= '0;
            out_imm_q    <= '0;
            out_opcode_q <= '0;
`ifdef OPFETCH_BYPASS_EN
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
`endif
        end else begin
            out_valid_q  <= out_valid_d;
            out_rs1_q    <= out_rs1_d;
            out_rs2_q    <= out_rs2_d;
            out_rd_q     <= out_rd_d;
            out_funct3_q <= out_funct3_d;
            out_funct7_q <= out_funct7_d;
            out_imm_q    <= out_imm_d;
            out_opcode_q <= out_opcode_d;
`ifdef OPFETCH_BYPASS_EN
            rs1_addr_q   <= rs1_addr_d;
            rs2_addr_q   <= rs2_addr_d;
`endif
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_rs1    = out_rs1_q;
    assign bus.out_rs2    = out_rs2_q;
    assign bus.out_rd     = out_rd_q;
    assign bus.out_funct3 = out_funct3_q;
    assign bus.out_funct7 = out_funct7_q;
    assign bus.out_imm    = out_imm_q;
    assign bus.out_opcode = out_opcode_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios followed by random traffic.
// A reference model predicts each accepted bundle into a queue; a monitor pops and
// compares on every output handshake.
module tb_operand_fetch_stage;
    localparam int DW = 32;
    localparam int RW = 5;
`ifdef OPFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    operand_fetch_stage_if #(.DATA_W(DW), .REG_SEL_W(RW)) bus ();

    operand_fetch_stage #(.DATA_W(DW), .REG_SEL_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DW:0]   rs1;
        logic [DW:0]   rs2;
        logic [RW:0]   rd;
        logic [3:0]    f3;
        logic [7:0]    f7;
        logic [DW:0]   imm;
        logic [6:0]    op;
        logic [RW-1:0] a1;
        logic [RW-1:0] a2;
    } exp_t;

    int errors = 0;
    int checks = 0;

    exp_t        exp_q[$];
    logic [DW-1:0] model_rf [32];
    bit          exp_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] mread(input logic en, input logic [RW-1:0] a);
        if (!en || a == 0) return '0;
        if (BYP && bus.wb_en && bus.wb_addr == a) return bus.wb_data;
        return model_rf[a];
    endfunction

    bit   m_rdy, m_acc, m_wbw;
    exp_t m_e;

    // Evaluated between edges, once inputs are stable, predicting the next edge.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            for (int i = 0; i < 32; i++) model_rf[i] = '0;
            exp_q.delete();
            exp_valid = 1'b0;
        end else begin
            m_rdy = !exp_valid || bus.out_ready;
            m_acc = bus.in_valid && m_rdy && !bus.flush;
            m_wbw = bus.wb_en && bus.wb_addr != 0;
            if (exp_valid && !bus.out_ready && exp_q.size() > 0) begin
                m_e = exp_q.pop_front();
                if (!bus.flush) begin
                    if (BYP && m_wbw) begin
                        if (m_e.rs1[0] && m_e.a1 == bus.wb_addr) m_e.rs1 = {bus.wb_data, 1'b1};
                        if (m_e.rs2[0] && m_e.a2 == bus.wb_addr) m_e.rs2 = {bus.wb_data, 1'b1};
                    end
                    exp_q.push_front(m_e);
                end
            end
            if (m_acc) begin
                m_e.rs1 = {mread(bus.in_rs1_en, bus.in_rs1_addr), bus.in_rs1_en};
                m_e.rs2 = {mread(bus.in_rs2_en, bus.in_rs2_addr), bus.in_rs2_en};
                m_e.rd  = {bus.in_rd_addr, bus.in_rd_en};
                m_e.f3  = bus.in_funct3;
                m_e.f7  = bus.in_funct7;
                m_e.imm = bus.in_imm;
                m_e.op  = bus.in_opcode;
                m_e.a1  = bus.in_rs1_addr;
                m_e.a2  = bus.in_rs2_addr;
                exp_q.push_back(m_e);
            end
            if (m_wbw) model_rf[bus.wb_addr] = bus.wb_data;
            if (m_acc)                            exp_valid = 1'b1;
            else if (bus.flush || bus.out_ready)  exp_valid = 1'b0;
        end
    end

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", {63'd0, bus.in_ready}, {63'd0, (!exp_valid || bus.out_ready)});
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_valid});
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got out_valid=1 expected no pending bundle (t=%0t)", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_rs1",    64'(bus.out_rs1),    64'(mon_e.rs1));
                    chk("out_rs2",    64'(bus.out_rs2),    64'(mon_e.rs2));
                    chk("out_rd",     64'(bus.out_rd),     64'(mon_e.rd));
                    chk("out_funct3", 64'(bus.out_funct3), 64'(mon_e.f3));
                    chk("out_funct7", 64'(bus.out_funct7), 64'(mon_e.f7));
                    chk("out_imm",    64'(bus.out_imm),    64'(mon_e.imm));
                    chk("out_opcode", 64'(bus.out_opcode), 64'(mon_e.op));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush = 0; bus.in_valid = 0; bus.wb_en = 0; bus.out_ready = 1;
        bus.in_rs1_en = 0; bus.in_rs2_en = 0; bus.in_rd_en = 0;
    endtask

    task automatic instr(input logic [RW-1:0] a1, input logic e1, input logic [RW-1:0] a2,
                         input logic e2, input logic [RW-1:0] rd, input logic [6:0] op,
                         input logic [DW:0] imm);
        bus.in_valid    = 1;
        bus.in_rs1_addr = a1; bus.in_rs1_en = e1;
        bus.in_rs2_addr = a2; bus.in_rs2_en = e2;
        bus.in_rd_addr  = rd; bus.in_rd_en  = 1;
        bus.in_funct3   = 4'($urandom);
        bus.in_funct7   = 8'($urandom);
        bus.in_imm      = imm;
        bus.in_opcode   = op;
    endtask

    task automatic wb(input logic [RW-1:0] a, input logic [DW-1:0] d);
        bus.wb_en = 1; bus.wb_addr = a; bus.wb_data = d;
    endtask

    initial begin
        idle();
        bus.in_rs1_addr = 0; bus.in_rs2_addr = 0; bus.in_rd_addr = 0;
        bus.in_funct3 = 0; bus.in_funct7 = 0; bus.in_imm = 0; bus.in_opcode = 0;
        bus.wb_addr = 0; bus.wb_data = 0;

        // T1: reset
        rst = 1; step(); step(); rst = 0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_rs1",   64'(bus.out_rs1),   64'd0);
        chk("rst_out_rs2",   64'(bus.out_rs2),   64'd0);
        chk("rst_out_rd",    64'(bus.out_rd),    64'd0);
        chk("rst_out_imm",   64'(bus.out_imm),   64'd0);
        chk("rst_out_f3f7op", {bus.out_funct3, bus.out_funct7, bus.out_opcode}, 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        for (int i = 0; i < 32; i++) begin
            instr(5'(i), 1, 5'(i), 1, 5'(i), 7'h33, 33'h0);
            step();
        end
        idle(); step();

        // T2: write then read
        wb(5, 32'hDEADBEEF); step();
        idle(); instr(5, 1, 0, 0, 3, 7'h13, {32'h10, 1'b1}); step();
        chk("t2_out_rs1", 64'(bus.out_rs1), {31'd0, 32'hDEADBEEF, 1'b1});
        idle(); step();

        // T3: register 0
        wb(0, 32'h1234); step();
        idle(); instr(0, 1, 0, 1, 1, 7'h33, 33'h0); step();
        chk("t3_out_rs1", 64'(bus.out_rs1), 64'd1);
        chk("t3_out_rs2", 64'(bus.out_rs2), 64'd1);
        idle(); step();

        // T4: stall
        bus.out_ready = 0;
        instr(5, 1, 0, 0, 9, 7'h03, {32'hCAFE, 1'b1}); step();
        instr(1, 1, 2, 1, 17, 7'h23, 33'h0);
        for (int c = 0; c < 3; c++) begin
            chk("t4_in_ready", 64'(bus.in_ready), 64'd0);
            chk("t4_out_rd",   64'(bus.out_rd),   {58'd0, 5'd9, 1'b1});
            chk("t4_out_imm",  64'(bus.out_imm),  {31'd0, 32'hCAFE, 1'b1});
            chk("t4_out_rs1",  64'(bus.out_rs1),  {31'd0, 32'hDEADBEEF, 1'b1});
            step();
        end
        bus.out_ready = 1; step();
        chk("t4_issue_valid", 64'(bus.out_valid), 64'd1);
        chk("t4_issue_rd",    64'(bus.out_rd),    {58'd0, 5'd17, 1'b1});
        idle(); step();

        // T5: flush
        bus.out_ready = 0;
        instr(5, 1, 5, 1, 4, 7'h33, 33'h0); step();
        chk("t5_valid_before", 64'(bus.out_valid), 64'd1);
        bus.flush = 1; instr(3, 1, 3, 1, 6, 7'h33, 33'h0); step();
        chk("t5_valid_after_flush", 64'(bus.out_valid), 64'd0);
        idle(); step();
        chk("t5_dropped", 64'(bus.out_valid), 64'd0);

        // T6: same-cycle write/read hazard
        wb(7, 32'h11); step();
        idle(); wb(7, 32'hA5); instr(0, 0, 7, 1, 2, 7'h33, 33'h0); step();
        chk("t6_hazard_rs2", 64'(bus.out_rs2), {31'd0, (BYP ? 32'hA5 : 32'h11), 1'b1});
        idle(); wb(7, 32'h11); step();
        idle(); bus.out_ready = 0; instr(0, 0, 7, 1, 2, 7'h33, 33'h0); step();
        chk("t6_stall_capture", 64'(bus.out_rs2), {31'd0, 32'h11, 1'b1});
        idle(); bus.out_ready = 0; wb(7, 32'hA5); step();
        chk("t6_stall_refresh", 64'(bus.out_rs2), {31'd0, (BYP ? 32'hA5 : 32'h11), 1'b1});
        idle(); step(); step();

        // Random traffic with a small register window to provoke hazards.
        for (int c = 0; c < 2000; c++) begin
            bus.flush     = ($urandom_range(0, 15) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.wb_en     = $urandom_range(0, 1);
            bus.wb_addr   = 5'($urandom_range(0, 7));
            bus.wb_data   = $urandom;
            instr(5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                  5'($urandom), 7'($urandom), {1'($urandom), 32'($urandom)});
            bus.in_rd_en  = 1'($urandom);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            step();
        end

        idle(); step(); step(); step();
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
